// File: rtl/flex_pkg.sv
// Shared definitions for the coefficient reader: state encoding,
// default parameter values and the SP-SRAM address width.
// Optional build macro used by the reader: COEFF_READ_STALL_EN.
package flex_pkg;

  localparam int NUM_TAPS_DEF = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage : flex_pkg

// File: rtl/coeff_reader_fsm_if.sv
// SP-SRAM read port shared between the coefficient reader (master)
// and the memory it reads from (slave).
interface coeff_reader_fsm_if
  import flex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              oCsn_Fsm;
  logic              oWrn_Fsm;
  logic [ADDR_W-1:0] oAddr_Fsm;
  logic [DATA_W-1:0] iRdData;

  modport master (
    output oCsn_Fsm,
    output oWrn_Fsm,
    output oAddr_Fsm,
    input  iRdData
  );

  modport slave (
    input  oCsn_Fsm,
    input  oWrn_Fsm,
    input  oAddr_Fsm,
    output iRdData
  );

endinterface : coeff_reader_fsm_if

// File: rtl/coeff_rd_pipe.sv
// Two-stage valid/index delay line. Stage 1 remembers which address was
// selected; stage 2 lines up with the SRAM read data and registers the
// coefficient word, so a word appears two cycles after its address.
// flush drops everything in flight, including a pending done pulse.
module coeff_rd_pipe
  import flex_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              flush,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] coeff,
  output logic [ADDR_W-1:0] coeff_idx,
  output logic              coeff_valid,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_idx;

  // Advance the valid/index pair and capture read data when stage 1 holds a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      coeff       <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
      done        <= 1'b0;
    end else if (flush) begin
      s1_valid    <= 1'b0;
      coeff_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      s1_valid    <= rd_en;
      s1_idx      <= rd_addr;
      coeff_valid <= s1_valid;
      coeff_idx   <= s1_idx;
      done        <= s1_valid && (s1_idx == LAST_IDX);
      if (s1_valid) begin
        coeff <= rd_data;
      end
    end
  end

endmodule : coeff_rd_pipe

// File: rtl/coeff_reader_fsm.sv
// Coefficient reader: on iStart walks SP-SRAM addresses 0..NUM_TAPS-1
// and streams the words out with their index, two cycles after each
// address. Top may take the SRAM back at any time via iUpdateFlag, which
// aborts the sequence and flushes anything in flight.
// Build macro COEFF_READ_STALL_EN adds iStall, which pauses READ.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | SRAM deselected, waiting for iStart with no update
// ST_READ  | one address per cycle (unless stalled), counter counts
// ST_DRAIN | SRAM deselected, two cycles for the last words to emerge
module coeff_reader_fsm
  import flex_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                  iClk12M,
  input  logic                  iRsn,
  input  logic                  iUpdateFlag,
  input  logic                  iStart,
`ifdef COEFF_READ_STALL_EN
  input  logic                  iStall,
`endif
  coeff_reader_fsm_if.master    sram,
  output logic [DATA_W-1:0]     oCoeff,
  output logic [ADDR_W-1:0]     oCoeffIdx,
  output logic                  oCoeffValid,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

  state_e            state_q, state_nx;
  logic [ADDR_W-1:0] cnt_q, cnt_nx;
  logic              drain_q, drain_nx;
  logic              stall;
  logic              rd_en;
  logic              flush;

`ifdef COEFF_READ_STALL_EN
  assign stall = iStall;
`else
  assign stall = 1'b0;
`endif

  // State, address counter and drain-cycle flag.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      drain_q <= drain_nx;
    end
  end

  // Next state and SRAM control; an update request deselects the SRAM
  // in the same cycle so Top never collides with a read.
  always_comb begin
    state_nx       = state_q;
    cnt_nx         = cnt_q;
    drain_nx       = drain_q;
    rd_en          = 1'b0;
    flush          = 1'b0;
    sram.oAddr_Fsm = '0;
    oBusy          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_nx   = '0;
        drain_nx = 1'b0;
        if (iStart && !iUpdateFlag) begin
          state_nx = ST_READ;
        end
      end

      ST_READ: begin
        oBusy          = 1'b1;
        sram.oAddr_Fsm = cnt_q;
        if (iUpdateFlag) begin
          flush    = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (!stall) begin
          rd_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_nx = ST_DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        oBusy = 1'b1;
        if (iUpdateFlag) begin
          flush    = 1'b1;
          state_nx = ST_IDLE;
          drain_nx = 1'b0;
        end else if (drain_q) begin
          state_nx = ST_IDLE;
          drain_nx = 1'b0;
        end else begin
          drain_nx = 1'b1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        drain_nx = 1'b0;
      end
    endcase
  end

  assign sram.oCsn_Fsm = ~rd_en;
  assign sram.oWrn_Fsm = 1'b1;

  coeff_rd_pipe #(
    .NUM_TAPS (NUM_TAPS),
    .DATA_W   (DATA_W)
  ) u_pipe (
    .clk         (iClk12M),
    .rst_n       (iRsn),
    .rd_en       (rd_en),
    .rd_addr     (cnt_q),
    .flush       (flush),
    .rd_data     (sram.iRdData),
    .coeff       (oCoeff),
    .coeff_idx   (oCoeffIdx),
    .coeff_valid (oCoeffValid),
    .done        (oDone)
  );

endmodule : coeff_reader_fsm

// File: tb/tb_coeff_reader_fsm.sv
// Self-checking bench for coeff_reader_fsm (default NUM_TAPS=16, DATA_W=16).
// Exercises the COEFF_READ_STALL_EN build when that macro is defined.
module tb_coeff_reader_fsm;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        upd;
  logic        start;
`ifdef COEFF_READ_STALL_EN
  logic        stall_in;
`endif
  logic [15:0] coeff;
  logic [3:0]  coeff_idx;
  logic        coeff_valid;
  logic        busy;
  logic        done;

  coeff_reader_fsm_if #(.DATA_W(16)) sram ();

  coeff_reader_fsm dut (
    .iClk12M     (clk),
    .iRsn        (rst_n),
    .iUpdateFlag (upd),
    .iStart      (start),
`ifdef COEFF_READ_STALL_EN
    .iStall      (stall_in),
`endif
    .sram        (sram),
    .oCoeff      (coeff),
    .oCoeffIdx   (coeff_idx),
    .oCoeffValid (coeff_valid),
    .oBusy       (busy),
    .oDone       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, data one cycle after a selected address.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (!sram.oCsn_Fsm) sram.iRdData <= mem[sram.oAddr_Fsm];
  end

  // Observation record for one sequence.
  int          cyc;
  int          a0_cyc, v0_cyc, done_cyc, done_cnt, wrn_bad;
  bit          done_ok;
  logic [3:0]  addr_q[$];
  logic [15:0] data_q[$];
  logic [3:0]  idx_q[$];

  initial cyc = 0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!sram.oCsn_Fsm) begin
      addr_q.push_back(sram.oAddr_Fsm);
      if (a0_cyc < 0) a0_cyc = cyc;
    end
    if (sram.oWrn_Fsm !== 1'b1) wrn_bad = wrn_bad + 1;
    if (coeff_valid) begin
      data_q.push_back(coeff);
      idx_q.push_back(coeff_idx);
      if (v0_cyc < 0) v0_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_ok  = coeff_valid && (coeff_idx == 4'(N - 1));
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    idx_q.delete();
    a0_cyc   = -1;
    v0_cyc   = -1;
    done_cyc = -1;
    done_cnt = 0;
    wrn_bad  = 0;
    done_ok  = 1'b0;
  endtask

  task automatic fill_mem(input bit ramp);
    for (int k = 0; k < 16; k++) mem[k] = ramp ? 16'(16'h1000 + k) : 16'($urandom);
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 of the cycle that presents address a.
  task automatic wait_addr(input int a);
    int n = 0;
    while (!(busy && !sram.oCsn_Fsm && sram.oAddr_Fsm == 4'(a)) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("addr_reach", {28'd0, sram.oAddr_Fsm}, 32'(a));
  endtask

  // Compare the recorded sequence against the expected stream: reads of
  // 0..n_addr-1 in order, words mem[k] tagged k, and for a complete run
  // all N words, one done on the last word, at fixed latencies.
  task automatic check_stream(input string tag, input int n_addr, input bit full, input int stall_cyc);
    chk({tag, "_nread"}, addr_q.size(), n_addr);
    foreach (addr_q[i]) chk({tag, "_addr"}, {28'd0, addr_q[i]}, 32'(i));
    if (full) begin
      chk({tag, "_nvalid"}, data_q.size(), N);
      chk({tag, "_ndone"}, done_cnt, 1);
      chk({tag, "_done_last"}, {31'd0, done_ok}, 1);
      chk({tag, "_lat"}, v0_cyc - a0_cyc, 2);
      chk({tag, "_done_cyc"}, done_cyc - a0_cyc, (N - 1) + 2 + stall_cyc);
    end else begin
      chk({tag, "_nvalid_le"}, {31'd0, data_q.size() <= n_addr}, 1);
      chk({tag, "_ndone"}, done_cnt, 0);
    end
    foreach (data_q[i]) begin
      chk({tag, "_idx"}, {28'd0, idx_q[i]}, 32'(i));
      chk({tag, "_data"}, {16'd0, data_q[i]}, {16'd0, mem[i]});
    end
    chk({tag, "_wrn"}, wrn_bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {3'd0, sram.oCsn_Fsm, sram.oWrn_Fsm, sram.oAddr_Fsm, coeff, coeff_idx, coeff_valid, busy, done},
        {3'd0, 1'b1, 1'b1, 27'd0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    upd   = 1'b0;
    start = 1'b0;
`ifdef COEFF_READ_STALL_EN
    stall_in = 1'b0;
`endif
    fill_mem(1'b1);
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_out");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Ramp contents: (0x1000+k, k) stream.
    clear_mon();
    start_pulse();
    wait_idle();
    check_stream("ramp", N, 1'b1, 0);

    // Start while Top owns the SRAM is ignored.
    clear_mon();
    upd = 1'b1;
    start_pulse();
    chk("upd_busy", {31'd0, busy}, 0);
    repeat (4) @(posedge clk);
    #1;
    upd = 1'b0;
    chk("upd_nread", addr_q.size(), 0);
    chk("upd_nvalid", data_q.size(), 0);
    chk("upd_busy2", {31'd0, busy}, 0);

    // Update raised at address 5 aborts.
    fill_mem(1'b0);
    clear_mon();
    start_pulse();
    wait_addr(5);
    upd = 1'b1;
    #1;
    chk("abort_csn", {31'd0, sram.oCsn_Fsm}, 1);
    @(posedge clk); #1;
    chk("abort_idle", {31'd0, busy}, 0);
    upd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_stream("abort5", 5, 1'b0, 0);

    // Reset at address 9, then no resume and a clean restart.
    fill_mem(1'b0);
    clear_mon();
    start_pulse();
    wait_addr(9);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset_out");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (4) @(posedge clk);
    #1;
    chk("no_resume_nread", addr_q.size(), 0);
    chk("no_resume_busy", {31'd0, busy}, 0);
    start_pulse();
    wait_idle();
    check_stream("restart", N, 1'b1, 0);

    // Randomized sequences: plain, with a stray start while busy, or aborted.
    for (int it = 0; it < 12; it++) begin
      int mode;
      int k;
      mode = $urandom_range(0, 2);
      fill_mem(1'b0);
      clear_mon();
      start_pulse();
      if (mode == 0) begin
        wait_idle();
        check_stream("rnd_plain", N, 1'b1, 0);
      end else if (mode == 1) begin
        k = $urandom_range(0, 10);
        repeat (k) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        check_stream("rnd_restart_ign", N, 1'b1, 0);
      end else begin
        k = $urandom_range(1, N - 1);
        wait_addr(k);
        upd = 1'b1;
        @(posedge clk); #1;
        chk("rnd_abort_idle", {31'd0, busy}, 0);
        upd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_stream("rnd_abort", k, 1'b0, 0);
      end
    end

`ifdef COEFF_READ_STALL_EN
    // Three stalled cycles at address 7.
    fill_mem(1'b0);
    clear_mon();
    start_pulse();
    wait_addr(7);
    stall_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_csn", {31'd0, sram.oCsn_Fsm}, 1);
      chk("stall_addr", {28'd0, sram.oAddr_Fsm}, 7);
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
    wait_idle();
    check_stream("stall", N, 1'b1, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_coeff_reader_fsm
